// File: rtl/countdown_timer.sv
// countdown_timer: presettable hh:mm:ss down-counter with run/pause control,
// a held done flag and a one-cycle expired pulse at 00:00:00.
module countdown_timer #(
   parameter int TICK_DIV = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [5:0] load_sec,
   input  logic [5:0] load_min,
   input  logic [4:0] load_hour,
   input  logic       start_stop,
   output logic [5:0] sec,
   output logic [5:0] min,
   output logic [4:0] hour,
   output logic       running,
   output logic       done,
   output logic       expired
);
   localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   state_t state_q, state_d;
   logic [5:0] sec_q, sec_d, min_q, min_d;
   logic [4:0] hour_q, hour_d;
   logic [PW-1:0] pre_q, pre_d;
   logic running_q, running_d, done_q, done_d, expired_q, expired_d;
   logic tick, zero, one;
   assign tick = state_q == RUN && pre_q == PW'(TICK_DIV - 1);
   assign zero = {hour_q, min_q, sec_q} == '0;
   assign one  = hour_q == '0 && min_q == '0 && sec_q == 6'd1;
   always_comb begin
      state_d   = state_q;
      sec_d     = sec_q;
      min_d     = min_q;
      hour_d    = hour_q;
      pre_d     = pre_q;
      expired_d = 1'b0;
      if (load) begin
         sec_d   = load_sec > 6'd59 ? 6'd59 : load_sec;
         min_d   = load_min > 6'd59 ? 6'd59 : load_min;
         hour_d  = load_hour > 5'd23 ? 5'd23 : load_hour;
         state_d = IDLE;
         pre_d   = '0;
      end else if (start_stop) begin
         state_d = state_q == IDLE  ? (zero ? IDLE : RUN) :
                   state_q == RUN   ? PAUSE :
                   state_q == PAUSE ? RUN : IDLE;
         pre_d   = state_q == IDLE ? '0 : pre_q;
      end else if (tick) begin
         // Borrow chain; a tick at 00:00:00 is impossible since reaching it leaves RUN.
         pre_d     = '0;
         sec_d     = sec_q != '0 ? sec_q - 6'd1 : 6'd59;
         min_d     = sec_q != '0 ? min_q : (min_q != '0 ? min_q - 6'd1 : 6'd59);
         hour_d    = sec_q == '0 && min_q == '0 ? hour_q - 5'd1 : hour_q;
         state_d   = one ? DONE : RUN;
         expired_d = one;
      end else if (state_q == RUN) begin
         pre_d = pre_q + PW'(1);
      end
      running_d = state_d == RUN;
      done_d    = state_d == DONE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         sec_q     <= '0;
         min_q     <= '0;
         hour_q    <= '0;
         pre_q     <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sec_q     <= sec_d;
         min_q     <= min_d;
         hour_q    <= hour_d;
         pre_q     <= pre_d;
         running_q <= running_d;
         done_q    <= done_d;
         expired_q <= expired_d;
      end
   end
   assign sec     = sec_q;
   assign min     = min_q;
   assign hour    = hour_q;
   assign running = running_q;
   assign done    = done_q;
   assign expired = expired_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed checks of two countdown_timer instances
// (TICK_DIV=1 and TICK_DIV=4) sharing the same stimulus.
module tb_countdown_timer;
   logic clk = 1'b0, rst = 1'b1, load = 1'b0, start_stop = 1'b0;
   logic [5:0] load_sec = '0, load_min = '0;
   logic [4:0] load_hour = '0;
   logic [5:0] sec1, min1, sec4, min4;
   logic [4:0] hour1, hour4;
   logic run1, done1, exp1, run4, done4, exp4;
   int checks = 0, errors = 0;
   countdown_timer #(.TICK_DIV(1)) u1 (
      .clk(clk), .rst(rst), .load(load), .load_sec(load_sec), .load_min(load_min),
      .load_hour(load_hour), .start_stop(start_stop), .sec(sec1), .min(min1),
      .hour(hour1), .running(run1), .done(done1), .expired(exp1)
   );
   countdown_timer #(.TICK_DIV(4)) u4 (
      .clk(clk), .rst(rst), .load(load), .load_sec(load_sec), .load_min(load_min),
      .load_hour(load_hour), .start_stop(start_stop), .sec(sec4), .min(min4),
      .hour(hour4), .running(run4), .done(done4), .expired(exp4)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input int obs, input int exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask
   task automatic step(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
      load = 1'b0;
      start_stop = 1'b0;
   endtask
   task automatic do_load(input int h, input int m, input int s);
      load_hour = 5'(h);
      load_min = 6'(m);
      load_sec = 6'(s);
      load = 1'b1;
      step();
   endtask
   task automatic press();
      start_stop = 1'b1;
      step();
   endtask
   initial begin
      step(3);
      chk("reset_time", {hour1, min1, sec1}, 0);
      chk("reset_flags", {run1, done1, exp1}, 0);
      rst = 1'b0;
      step();
      do_load(0, 0, 3);
      chk("t1_load", sec1, 3);
      press();
      chk("t1_running", run1, 1);
      chk("t1_sec_hold", sec1, 3);
      step();
      chk("t1_sec2", sec1, 2);
      step();
      chk("t1_sec1", sec1, 1);
      chk("t1_no_exp", exp1, 0);
      step();
      chk("t1_sec0", sec1, 0);
      chk("t1_flags_at_expiry", {run1, done1, exp1}, 3'b011);
      step();
      chk("t1_flags_after", {run1, done1, exp1}, 3'b010);
      chk("t1_frozen", {hour1, min1, sec1}, 0);
      press();
      chk("t5_done_ack", {run1, done1}, 0);
      do_load(1, 0, 0);
      press();
      step();
      chk("t2_hour_borrow", {hour1, min1, sec1}, {5'd0, 6'd59, 6'd59});
      do_load(0, 1, 0);
      press();
      step();
      chk("t2_min_borrow", {hour1, min1, sec1}, {5'd0, 6'd0, 6'd59});
      load_hour = 5'd0;
      load_min = 6'd0;
      load_sec = 6'd9;
      load = 1'b1;
      start_stop = 1'b1;
      step();
      chk("t5_load_over_ss", {run1, sec1}, {1'b0, 6'd9});
      do_load(30, 63, 61);
      chk("t4_clamp", {hour1, min1, sec1}, {5'd23, 6'd59, 6'd59});
      do_load(0, 0, 0);
      press();
      chk("t4_zero_start", {run1, done1, sec1}, 0);
      do_load(0, 0, 10);
      press();
      chk("t3_run", run4, 1);
      step(2);
      chk("t3_pre_sec", sec4, 10);
      press();
      chk("t3_paused", {run4, sec4}, {1'b0, 6'd10});
      step(10);
      chk("t3_hold", {run4, sec4}, {1'b0, 6'd10});
      press();
      chk("t3_resume", {run4, sec4}, {1'b1, 6'd10});
      step();
      chk("t3_r1", sec4, 10);
      step();
      chk("t3_r2_dec", sec4, 9);
      step(3);
      chk("t3_r5", sec4, 9);
      step();
      chk("t3_r6_dec", sec4, 8);
      do_load(0, 5, 7);
      press();
      chk("t6_run", {run1, min1, sec1}, {1'b1, 6'd5, 6'd7});
      #2 rst = 1'b1;
      #1;
      chk("t6_async_time", {hour1, min1, sec1}, 0);
      chk("t6_async_flags", {run1, done1, exp1}, 0);
      step(2);
      rst = 1'b0;
      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
